// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // True when any byte-address bit above the store's word index is set.
  function automatic logic addr_oob(
    input logic [31:0] addr,
    input int unsigned aw
  );
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word store: one synchronous read port, one byte-enabled write port.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  input  logic [3:0]    wr_be_i
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Read samples the array before this edge's write lands.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_idx_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory with wait states and valid/ready response.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_inst_o,
  output logic        rsp_err_o,
  input  logic        flush_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_be_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;
  logic             accept;
  logic             wr_ok;
  logic [31:0]      rd_data;
  logic [1:0]       unused_wr_lsb;

  assign unused_wr_lsb = wr_addr_i[1:0];

  always_comb begin
    req_ready_o = !flush_i &&
                  (state_q == S_IDLE ||
                   (state_q == S_RESP && rsp_ready_i));
    accept  = req_valid_i && req_ready_o;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      cnt_d   = WS;
      err_d   = (req_addr_i[1:0] != 2'b00) ||
                addr_oob(req_addr_i, AW);
      state_d = (WS == '0) ? S_RESP : S_WAIT;
    end

    // Redirect kills whatever is in flight, including a held response.
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign wr_ok = wr_en_i && !addr_oob(wr_addr_i, AW);

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_en_i  (accept),
    .rd_idx_i (req_addr_i[2 +: AW]),
    .rd_data_o(rd_data),
    .wr_en_i  (wr_ok),
    .wr_idx_i (wr_addr_i[2 +: AW]),
    .wr_data_i(wr_data_i),
    .wr_be_i  (wr_be_i)
  );

  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_err_o   = err_q;
  assign rsp_inst_o  = err_q ? NOP_INST : rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// Drives two responders (1 and 0 wait states) against a transaction model.
module tb_imem_responder;

  localparam int DEPTH = 4096;
  localparam logic [31:0] LIM = 32'(DEPTH * 4);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        rsp_ready_i;
  logic        flush_i;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_be_i;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_inst  [2];
  logic        rsp_err   [2];

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready_i),
    .rsp_inst_o(rsp_inst[0]), .rsp_err_o(rsp_err[0]),
    .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_be_i(wr_be_i)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready_i),
    .rsp_inst_o(rsp_inst[1]), .rsp_err_o(rsp_err[1]),
    .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_be_i(wr_be_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Transaction-level model: outstanding flag, cycles to valid, payload.
  logic [31:0] mem_m [DEPTH];
  bit          pend     [2];
  int          wl       [2];
  logic [31:0] ex_inst  [2];
  bit          ex_err   [2];
  bit          post_rst [2];
  int          ws_m     [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  task automatic step(input bit v, input logic [31:0] a, input bit rr,
                      input bit fl, input bit we, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [3:0] be,
                      input bit r);
    @(negedge clk);
    rst = r; req_valid_i = v; req_addr_i = a; rsp_ready_i = rr;
    flush_i = fl; wr_en_i = we; wr_addr_i = wa;
    wr_data_i = wd; wr_be_i = be;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit ev;
      bit er;
      ev = pend[k] && wl[k] == 0;
      er = !fl && (!pend[k] || (ev && rr));
      if (chk_en) begin
        chk($sformatf("m%0d_valid", k), rsp_valid[k], ev);
        chk($sformatf("m%0d_ready", k), req_ready[k], er);
        if (ev) begin
          chk($sformatf("m%0d_inst", k), rsp_inst[k], ex_inst[k]);
          chk($sformatf("m%0d_err", k), rsp_err[k], ex_err[k]);
        end
        if (post_rst[k]) begin
          chk($sformatf("m%0d_rst_inst", k), rsp_inst[k], 0);
          chk($sformatf("m%0d_rst_err", k), rsp_err[k], 0);
        end
      end
      post_rst[k] = 0;
      if (r) begin
        pend[k] = 0;
        post_rst[k] = 1;
      end else begin
        if (fl || (ev && rr)) pend[k] = 0;
        else if (pend[k] && wl[k] != 0) wl[k]--;
        if (v && er) begin
          pend[k] = 1;
          wl[k] = ws_m[k];
          ex_err[k] = (a[1:0] != 2'b00) || (a >= LIM);
          ex_inst[k] = ex_err[k] ? NOP : mem_m[a[13:2]];
        end
      end
    end
    if (we && wa < LIM) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[wa[13:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic idle(input bit rr);
    step(0, 0, rr, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic req(input logic [31:0] a, input bit rr);
    step(1, a, rr, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [31:0] wa, input logic [31:0] wd,
                    input logic [3:0] be);
    step(0, 0, 1, 0, 1, wa, wd, be, 0);
  endtask

  // Both responders idle on entry and on exit.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                       input bit ee, input string tag);
    req(a, 0);
    idle(0);
    idle(0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_v%0d", tag, k), rsp_valid[k], 1);
      chk($sformatf("%s_i%0d", tag, k), rsp_inst[k], ei);
      chk($sformatf("%s_e%0d", tag, k), rsp_err[k], ee);
    end
    idle(1);
    idle(1);
  endtask

  function automatic logic [31:0] rand_addr();
    int w;
    w = $urandom_range(0, 15);
    case ($urandom_range(0, 9))
      0: return 32'(w * 4) | 32'($urandom_range(1, 3));
      1: return ($urandom | 32'h4000) & ~32'h3;
      2: return 32'((DEPTH - 1) * 4);
      default: return 32'(w * 4);
    endcase
  endfunction

  initial begin
    ws_m[0] = 1;
    ws_m[1] = 0;
    rst = 1; req_valid_i = 0; req_addr_i = 0; rsp_ready_i = 0;
    flush_i = 0; wr_en_i = 0; wr_addr_i = 0; wr_data_i = 0; wr_be_i = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk_en = 1;

    idle(0);
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", rsp_valid[k], 0);
      chk("reset_ready", req_ready[k], 1);
      chk("reset_inst", rsp_inst[k], 0);
    end

    wr(0, 32'h0010_0093, 4'hF);
    for (int i = 1; i < 16; i++) wr(32'(i * 4), pat(i), 4'hF);
    wr(32'((DEPTH - 1) * 4), pat(DEPTH - 1), 4'hF);

    req(0, 1);
    idle(1);
    chk("lat_early", rsp_valid[0], 0);
    idle(1);
    chk("lat_valid", rsp_valid[0], 1);
    chk("lat_inst", rsp_inst[0], 32'h0010_0093);
    chk("lat_err", rsp_err[0], 0);
    idle(1);

    req(0, 0);
    idle(0);
    for (int i = 0; i < 5; i++) begin
      req(4, 0);
      chk("bp_valid", rsp_valid[0], 1);
      chk("bp_inst", rsp_inst[0], 32'h0010_0093);
      chk("bp_ready", req_ready[0], 0);
    end
    req(4, 1);
    chk("bp_accept", req_ready[0], 1);
    idle(1);
    idle(1);
    chk("bp_next", rsp_inst[0], pat(1));
    idle(1);

    fetch(2, NOP, 1, "misal");
    fetch(32'h0000_4000, NOP, 1, "oor");
    fetch(32'((DEPTH - 1) * 4), pat(DEPTH - 1), 0, "top");

    req(0, 1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    idle(0);
    chk("fw_valid", rsp_valid[0], 0);
    chk("fw_idle", req_ready[0], 1);
    idle(0);
    chk("fw_valid2", rsp_valid[0], 0);

    req(0, 0);
    idle(0);
    step(1, 4, 1, 1, 0, 0, 0, 0, 0);
    chk("fr_noacc", req_ready[0], 0);
    idle(0);
    chk("fr_drop", rsp_valid[0], 0);
    idle(0);
    chk("fr_none", rsp_valid[0], 0);

    step(1, 8, 0, 0, 1, 8, 32'hDEAD_BEEF, 4'hF, 0);
    idle(0);
    idle(0);
    chk("col_old1", rsp_inst[0], pat(2));
    chk("col_old0", rsp_inst[1], pat(2));
    idle(1);
    idle(1);
    fetch(8, 32'hDEAD_BEEF, 0, "col_new");
    wr(8, 32'h0000_AA00, 4'b0010);
    fetch(8, 32'hDEAD_AAEF, 0, "be");

    req(0, 0);
    idle(0);
    idle(0);
    step(1, 4, 1, 1, 0, 0, 0, 0, 1);
    idle(0);
    for (int k = 0; k < 2; k++) begin
      chk("rr_valid", rsp_valid[k], 0);
      chk("rr_ready", req_ready[k], 1);
      chk("rr_inst", rsp_inst[k], 0);
      chk("rr_err", rsp_err[k], 0);
    end

    req(0, 1);
    req(4, 1);
    chk("tp_v0", rsp_valid[1], 1);
    chk("tp_i0", rsp_inst[1], 32'h0010_0093);
    req(8, 1);
    chk("tp_v1", rsp_valid[1], 1);
    chk("tp_i1", rsp_inst[1], pat(1));
    idle(1);
    chk("tp_v2", rsp_valid[1], 1);
    chk("tp_i2", rsp_inst[1], 32'hDEAD_AAEF);
    idle(1);
    idle(1);
    idle(1);

    for (int n = 0; n < 3000; n++) begin
      bit v, rr, fl, we, r;
      logic [31:0] a, wa;
      v  = $urandom_range(0, 3) != 0;
      rr = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 19) == 0;
      r  = $urandom_range(0, 99) == 0;
      we = !r && $urandom_range(0, 3) == 0;
      a  = rand_addr();
      wa = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) wa = wa | 32'h4000;
      step(v, a, rr, fl, we, wa, $urandom, 4'($urandom), r);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the fetch path. It accepts word fetch requests carrying the PC address, reads the addressed word from a local instruction store after a configurable number of wait states, and returns the instruction over a valid/ready response channel. A byte-enabled write port lets the boot or test loader fill the store. The block sits between the fetch stage and program storage, taking the place of a purely combinational ROM so the pipeline sees real fetch latency and backpressure.

## Interface
- `DEPTH_WORDS`, default 4096: number of 32-bit words in the store; must be a power of two.
- `WAIT_STATES`, default 1: extra cycles between request acceptance and response valid; legal range 0..15.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_valid_i`  in  1: fetch request valid.
- `req_ready_o`  out  1: responder can accept a request this cycle.
- `req_addr_i`  in  32: byte address of the instruction (PC).
- `rsp_valid_o`  out  1: response valid.
- `rsp_ready_i`  in  1: fetch stage accepts the response.
- `rsp_inst_o`  out  32: instruction word.
- `rsp_err_o`  out  1: access fault, meaning the address is misaligned or out of range.
- `flush_i`  in  1: discard any in-flight request or pending response (redirect).
- `wr_en_i`  in  1: loader write strobe.
- `wr_addr_i`  in  32: loader byte address; bits [1:0] are ignored.
- `wr_data_i`  in  32: loader write data.
- `wr_be_i`  in  4: byte enables; bit n writes byte lane n.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request accepted, wait-state counter running.
  - RESP: response held valid.
- `req_ready_o` is 1 when `!flush_i`, and the FSM is either in IDLE or in RESP with `rsp_ready_i` = 1.
- Acceptance happens on a cycle with `req_valid_i & req_ready_o`. On acceptance:
  - The store is read at word index `req_addr_i[2 +: log2(DEPTH_WORDS)]` into the data register.
  - The error flag is computed and registered.
  - The counter is loaded with `WAIT_STATES`.
  - Next state is RESP if `WAIT_STATES` == 0, otherwise WAIT.
- Error rule:
  - `rsp_err_o` = 1 when `req_addr_i[1:0]` != 0, or when any address bit at or above `2 + log2(DEPTH_WORDS)` is set.
  - When the error flag is set, `rsp_inst_o` = 32'h0000_0013 (NOP) in place of store data.
- WAIT: the counter decrements each cycle. When it reaches 1, the next state is RESP.
- RESP:
  - `rsp_valid_o`, `rsp_inst_o` and `rsp_err_o` are held stable until `rsp_ready_i` = 1.
  - On the handshake, the next state is IDLE, or WAIT/RESP if a new request is accepted in the same cycle (back-to-back).
- Flush:
  - `flush_i` = 1 in any state forces IDLE next cycle, with `rsp_valid_o` = 0 next cycle.
  - A response that is valid in the same cycle as `flush_i` is dropped, even if `rsp_ready_i` = 1.
  - No request is accepted in a flush cycle.
- Loader write: when `wr_en_i` = 1, the enabled bytes are written at index `wr_addr_i[2 +: log2(DEPTH_WORDS)]`.
  - Out-of-range write addresses are dropped silently.
  - Writes proceed in any FSM state.
- Read/write collision: a write to the same word in the acceptance cycle is not visible to that read (read-before-write). Writes after acceptance do not alter the captured response.
- Reset:
  - FSM returns to IDLE and the counter to 0.
  - `rsp_valid_o` = 0, `rsp_inst_o` = 0, `rsp_err_o` = 0, `req_ready_o` = 1 (with `flush_i` low).
  - Store contents are not reset.
  - Reset overrides a simultaneous flush, request or response.

## Timing
- Latency: a request accepted at cycle T gives `rsp_valid_o` = 1 at cycle T+1+`WAIT_STATES`.
- Throughput:
  - `WAIT_STATES` = 0 with `rsp_ready_i` held high: one response per cycle.
  - Otherwise: one response per 1+`WAIT_STATES` cycles.
- `req_ready_o` has a combinational path from `rsp_ready_i` and `flush_i`.
- All other outputs are registered.
- Writes take effect at the clock edge of the `wr_en_i` cycle, and are visible to a request accepted in the next cycle.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - the `NOP_INST` constant 32'h0000_0013;
  - the 4-bit wait-counter width.
- Sub-module `imem_array`: a `DEPTH_WORDS` x 32 store with one synchronous read port, one byte-enabled write port, and read-before-write on collision.
- The FSM, counter, error check and response registers live in `imem_responder`.

## Test plan
- `WAIT_STATES`=1:
  - Load 32'h0010_0093 at 0x0.
  - Request 0x0 with `rsp_ready_i`=1.
  - Expect `rsp_valid_o`=1 two cycles after acceptance, with `rsp_inst_o`=32'h0010_0093 and `rsp_err_o`=0.
- Backpressure:
  - Hold `rsp_ready_i`=0 for 5 cycles in RESP.
  - Expect the response held stable and `req_ready_o`=0 throughout.
  - Raise `rsp_ready_i` together with a new request to 0x4; expect it to be accepted that cycle.
- Faults:
  - Request 0x2; expect `rsp_err_o`=1 and `rsp_inst_o`=32'h0000_0013.
  - Request 0x0000_4000 with `DEPTH_WORDS`=4096; expect the same error response.
- Flush:
  - Assert `flush_i` in WAIT; expect `rsp_valid_o` to stay 0 and state to be IDLE next cycle.
  - Assert `flush_i` in RESP with `rsp_ready_i`=1; expect the response dropped and the same-cycle request not accepted.
- Collision:
  - Write 32'hDEAD_BEEF to 0x8 in the acceptance cycle of a read to 0x8; expect the old word returned.
  - Read 0x8 again; expect 32'hDEAD_BEEF.
  - Partial write with `wr_be_i`=4'b0010 and `wr_data_i`=32'h0000_AA00; expect only byte 1 changed.
- Reset and throughput:
  - Assert `rst` in RESP; expect all outputs at their reset values next cycle.
  - With `WAIT_STATES`=0, issue back-to-back requests 0x0, 0x4, 0x8; expect three consecutive valid cycles.
